mode_onehot_sequencer: RTL
==========================

Name: mode_onehot_sequencer

Overview:
Registered, parametrised mode decoder for the multi-mode counter. It turns a MODE_W-bit mode select into a one-hot enable bus D for the counter sub-blocks. A mode is committed only after it has been stable for STABLE_CYCLES samples and is legal under MODE_MASK. On every switch, D is driven all-zero for GUARD_CYCLES cycles (break-before-make), so two counter modes are never enabled at the same time.

Parameters:
MODE_W, 3, mode select width; D width is 2**MODE_W
STABLE_CYCLES, 4, consecutive identical Mode samples required to commit; must be >= 1
GUARD_CYCLES, 2, cycles D is held all-zero between modes; 0 allowed
MODE_MASK, all ones (2**MODE_W bits), bit i = 1 means mode i is legal

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
En  input  1  block enable; low forces the IDLE state
Mode  input  MODE_W  requested mode
D  output  2**MODE_W  registered one-hot enable, or all-zero
CurMode  output  MODE_W  last committed mode
Valid  output  1  high when D carries a committed one-hot value
Busy  output  1  high in QUALIFY or GUARD
Changed  output  1  one-cycle pulse on the first ACTIVE cycle after a commit
Err  output  1  one-cycle pulse when a qualified mode is illegal

Behaviour:
- One clock domain. Reset is asynchronous and active-high; all registers clear immediately when it asserts.
- Reset values: D=0, CurMode=0, Valid=0, Busy=0, Changed=0, Err=0, state=IDLE, stab_cnt=0, cand=0, rej_vld=0.
- All outputs are registered. There is no combinational path from any input to any output.
- States:
  - IDLE: D=0, Valid=0.
  - QUALIFY: candidate mode is being checked for stability.
  - GUARD: D=0 between modes.
  - ACTIVE: committed mode is driven on D.
- En=0 in any state: next state is IDLE, D=0, Valid=0, Busy=0, rej_vld cleared. CurMode is retained. En has priority over all transitions below.
- IDLE, En=1: cand=Mode, stab_cnt=1, go to QUALIFY. This applies even when Mode equals the retained CurMode. If rej_vld=1 and Mode equals the rejected value, stay in IDLE.
- QUALIFY:
  - Mode != cand: cand=Mode, stab_cnt=1 (restart).
  - Entered from ACTIVE and Mode == CurMode: abort back to ACTIVE. No Changed pulse, D unchanged.
  - Otherwise stab_cnt increments. On the edge that takes the STABLE_CYCLES-th matching sample:
    - cand legal (MODE_MASK[cand]=1): go to GUARD, or directly to ACTIVE if GUARD_CYCLES=0.
    - cand illegal: Err=1 for one cycle, record rejected value, rej_vld=1, return to the previous state (ACTIVE with old D, or IDLE).
  - When STABLE_CYCLES=1, the entry sample commits immediately.
- ACTIVE: D = 1 << CurMode, Valid=1, Busy=0. If Mode != CurMode and Mode is not the rejected value (when rej_vld=1), go to QUALIFY with cand=Mode, stab_cnt=1. D and Valid stay at the old mode throughout QUALIFY.
- GUARD: D=0, Valid=0, Busy=1 for exactly GUARD_CYCLES cycles. Mode changes are ignored while in GUARD. Then go to ACTIVE with CurMode=cand and Changed=1 for one cycle.
- rej_vld clears when Mode differs from the rejected value, or when En=0.
- Latency: let edge k be the first qualifying sample with Mode stable. D becomes one-hot after edge k+STABLE_CYCLES+GUARD_CYCLES-1, which is k+5 with defaults. The same edge updates CurMode and raises Valid and Changed.
- Invariant: popcount(D) <= 1 at every cycle, and Valid=1 exactly when popcount(D)=1.
- Reset mid-operation (any state): all registers clear asynchronously. After release the block starts from IDLE; no stale Changed or Err pulse appears.

Test Plan:
- Reset, then En=1, Mode=3 held: D=0 for edges k..k+4, then D=8'h08, CurMode=3, Valid=1 and Changed=1 for one cycle at edge k+5.
- ACTIVE in mode 3, then Mode toggles 5,6,5,6 every cycle: never qualifies; D stays 8'h08, Busy=1, no Changed pulse.
- ACTIVE in mode 3, Mode=7 held: D stays 8'h08 for 4 samples, then D=0 for 2 cycles, then D=8'h80 with a Changed pulse. popcount(D) <= 1 is checked throughout.
- MODE_MASK=8'h7F, Mode=7 held from ACTIVE mode 2: Err pulses once at the 4th sample, D stays 8'h04, and there is no further Err while Mode stays 7. Mode=1 then commits normally.
- ACTIVE mode 4, Mode=0 for 2 cycles then back to 4: QUALIFY aborts, D stays 8'h10, no GUARD, no Changed.
- Reset asserted in the middle of GUARD (not aligned to Clk): D=0, Valid=0, CurMode=0 immediately. After release, En=1 and Mode=1 give D=8'h02 after 6 edges. Repeat with En=0 instead of reset: IDLE next edge and CurMode retained.

Source files
------------

// File: rtl/mode_onehot_sequencer_if.sv
// rtl/mode_onehot_sequencer_if.sv - mode select in, one-hot enable bus and status out
interface mode_onehot_sequencer_if #(
    parameter int MODE_W = 3
);
    logic                   En;
    logic [MODE_W-1:0]      Mode;
    logic [2**MODE_W-1:0]   D;
    logic [MODE_W-1:0]      CurMode;
    logic                   Valid;
    logic                   Busy;
    logic                   Changed;
    logic                   Err;

    modport master (
        output En, Mode,
        input  D, CurMode, Valid, Busy, Changed, Err
    );

    modport slave (
        input  En, Mode,
        output D, CurMode, Valid, Busy, Changed, Err
    );
endinterface

// File: rtl/mode_onehot_sequencer.sv
// rtl/mode_onehot_sequencer.sv - debounced mode select to one-hot enable with break-before-make guard
module mode_onehot_sequencer #(
    parameter int                  MODE_W        = 3,
    parameter int                  STABLE_CYCLES = 4,
    parameter int                  GUARD_CYCLES  = 2,
    parameter logic [2**MODE_W-1:0] MODE_MASK    = '1
) (
    input  logic Clk,
    input  logic Reset,
    mode_onehot_sequencer_if.slave bus
);
    localparam int N  = 2**MODE_W;
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [N-1:0] ONE = N'(1);

    typedef enum logic [1:0] {IDLE, QUALIFY, GUARD, ACTIVE} state_t;

    state_t             state;
    logic [SW-1:0]      stab_cnt;
    logic [MODE_W-1:0]  cand;
    logic               rej_vld;
    logic [MODE_W-1:0]  rej_val;
    logic               from_active;
    logic [GW-1:0]      guard_cnt;
    logic [N-1:0]       d;
    logic [MODE_W-1:0]  cur_mode;
    logic               valid;
    logic               busy;
    logic               changed;
    logic               err;

    logic               blocked;
    logic               abort;
    logic               entry_ok;
    logic               commit_now;
    logic [SW-1:0]      stab_next;

    assign blocked   = rej_vld && (bus.Mode == rej_val);
    assign abort     = (state == QUALIFY) && from_active && (bus.Mode == cur_mode);
    assign stab_next = stab_cnt + SW'(1);

    always_comb begin
        entry_ok = 1'b0;
        if (state == IDLE)
            entry_ok = !blocked;
        else if (state == ACTIVE)
            entry_ok = (bus.Mode != cur_mode) && !blocked;
    end

    // The qualifying sample that reaches STABLE_CYCLES commits, including the entry sample when it is 1.
    always_comb begin
        commit_now = 1'b0;
        if (bus.En) begin
            if (entry_ok)
                commit_now = (STABLE_CYCLES == 1);
            else if (state == QUALIFY && !abort && bus.Mode == cand)
                commit_now = (stab_next == SW'(STABLE_CYCLES));
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            stab_cnt    <= '0;
            cand        <= '0;
            rej_vld     <= 1'b0;
            rej_val     <= '0;
            from_active <= 1'b0;
            guard_cnt   <= '0;
            d           <= '0;
            cur_mode    <= '0;
            valid       <= 1'b0;
            busy        <= 1'b0;
            changed     <= 1'b0;
            err         <= 1'b0;
        end else begin
            changed <= 1'b0;
            err     <= 1'b0;
            if (rej_vld && bus.Mode != rej_val)
                rej_vld <= 1'b0;

            if (!bus.En) begin
                state       <= IDLE;
                d           <= '0;
                valid       <= 1'b0;
                busy        <= 1'b0;
                rej_vld     <= 1'b0;
                from_active <= 1'b0;
            end else if (commit_now) begin
                from_active <= 1'b0;
                if (MODE_MASK[bus.Mode]) begin
                    if (GUARD_CYCLES == 0) begin
                        state    <= ACTIVE;
                        cur_mode <= bus.Mode;
                        d        <= ONE << bus.Mode;
                        valid    <= 1'b1;
                        busy     <= 1'b0;
                        changed  <= 1'b1;
                    end else begin
                        state     <= GUARD;
                        cand      <= bus.Mode;
                        guard_cnt <= '0;
                        d         <= '0;
                        valid     <= 1'b0;
                        busy      <= 1'b1;
                    end
                end else begin
                    // Illegal mode: fall back to wherever we came from, old D untouched.
                    err     <= 1'b1;
                    rej_val <= bus.Mode;
                    rej_vld <= 1'b1;
                    busy    <= 1'b0;
                    state   <= (state == ACTIVE || from_active) ? ACTIVE : IDLE;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (!blocked) begin
                            cand        <= bus.Mode;
                            stab_cnt    <= SW'(1);
                            from_active <= 1'b0;
                            busy        <= 1'b1;
                            state       <= QUALIFY;
                        end
                    end
                    QUALIFY: begin
                        if (abort) begin
                            state       <= ACTIVE;
                            busy        <= 1'b0;
                            from_active <= 1'b0;
                        end else if (bus.Mode != cand) begin
                            cand     <= bus.Mode;
                            stab_cnt <= SW'(1);
                        end else begin
                            stab_cnt <= stab_next;
                        end
                    end
                    GUARD: begin
                        if (guard_cnt == GW'(GUARD_CYCLES - 1)) begin
                            state    <= ACTIVE;
                            cur_mode <= cand;
                            d        <= ONE << cand;
                            valid    <= 1'b1;
                            busy     <= 1'b0;
                            changed  <= 1'b1;
                        end else begin
                            guard_cnt <= guard_cnt + GW'(1);
                        end
                    end
                    ACTIVE: begin
                        if (bus.Mode != cur_mode && !blocked) begin
                            cand        <= bus.Mode;
                            stab_cnt    <= SW'(1);
                            from_active <= 1'b1;
                            busy        <= 1'b1;
                            state       <= QUALIFY;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.D       = d;
    assign bus.CurMode = cur_mode;
    assign bus.Valid   = valid;
    assign bus.Busy    = busy;
    assign bus.Changed = changed;
    assign bus.Err     = err;
endmodule
